register_scoreboard: RTL
========================

Name: register_scoreboard

Overview:
- Tracks in-flight register writes from decode/issue (ID->EX transfer) until they retire at writeback.
- Stalls issue on load-use hazards: the source register is written by a load whose data has not reached MEM/WB, where the forwarding path cannot supply it.
- Stalls issue when a destination's in-flight counter is saturated.
- Sits beside the forwarding unit in Core/Control and drives the decode-stage stall.

Parameters:
- COUNT_WIDTH, 2, width of the per-register in-flight write counter; maximum count = 2^COUNT_WIDTH-1.
- LOAD_COUNT_WIDTH, 2, width of the per-register load-not-ready counter.

Ports:
- clock  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- issueValid  input  1  decode holds a valid instruction that wants to move to EX.
- issueRd  input  5  destination register of the issuing instruction.
- issueWritesRd  input  1  issuing instruction writes a GPR (ALU, PC4, load or CSR read).
- issueIsLoad  input  1  issuing instruction is a load.
- issueRs1  input  5  source register 1.
- issueRs2  input  5  source register 2.
- issueUsesRs1  input  1  rs1 is actually read.
- issueUsesRs2  input  1  rs2 is actually read.
- loadReadyValid  input  1  a load has entered MEM/WB this cycle and is now forwardable.
- loadReadyRd  input  5  destination of that load.
- retireValid  input  1  an instruction with a GPR write retires at writeback.
- retireRd  input  5  its destination.
- killValid  input  1  an in-flight GPR-writing instruction is squashed by a branch or trap flush.
- killRd  input  5  its destination.
- killLoadPending  input  1  the killed instruction is a load not yet reported by loadReadyValid.
- stall  output  1  combinational; holds decode this cycle.
- issueAccept  output  1  issueValid && !stall; the issue was recorded.
- busyVector  output  32  registered; bit r = in-flight count of r != 0.
- loadBusyVector  output  32  registered; bit r = load-not-ready count of r != 0.
- scoreboardError  output  1  sticky; set on counter underflow or overflow.

Behaviour:
- State:
  - pendCount[1..31], width COUNT_WIDTH.
  - loadCount[1..31], width LOAD_COUNT_WIDTH.
  - Register x0 is never tracked; every event with rd = 0 is ignored.
- Reset: all counters 0; busyVector = 0; loadBusyVector = 0; scoreboardError = 0. Reset asserted mid-operation discards all in-flight state in the same edge.
- stall is computed from registered state and the current-cycle issue inputs only. It asserts when any of the following holds:
  - issueUsesRs1 && issueRs1 != 0 && loadCount[issueRs1] != 0.
  - issueUsesRs2 && issueRs2 != 0 && loadCount[issueRs2] != 0.
  - issueWritesRd && issueRd != 0 && pendCount[issueRd] == max.
  - issueIsLoad && issueRd != 0 && loadCount[issueRd] == max.
- stall is forced 0 when issueValid = 0.
- A loadReadyValid in the same cycle does not clear stall; the stall releases the following cycle (one-cycle bubble).
- Per-register update at the clock edge. All events apply simultaneously, and each register nets its own deltas:
  - pendCount: +1 on issueAccept && issueWritesRd; -1 on retireValid; -1 on killValid.
  - loadCount: +1 on issueAccept && issueIsLoad; -1 on loadReadyValid; -1 on killValid && killLoadPending.
  - Example: issue and retire to the same rd in one cycle leaves the count unchanged.
  - Kill and retire of the same rd in one cycle subtract 2.
- Invariant: loadCount[r] <= pendCount[r].
- Underflow (a decrement on 0) or overflow (an increment at max with no matching decrement): the counter saturates and scoreboardError sets. Only reset clears scoreboardError.
- busyVector and loadBusyVector reflect post-update counts, so they are valid the cycle after the edge. Bit 0 is always 0.
- Latency: issue-to-visible-busy is 1 cycle; retire-to-clear is 1 cycle.

Test Plan:
- Reset, then issue `add x5` (no load) with a dependent `add` using rs1 = x5 next cycle -> stall = 0; busyVector[5] = 1; loadBusyVector[5] = 0.
- Issue load x7; the next instruction uses rs2 = x7 -> stall = 1, issueAccept = 0. Pulse loadReadyValid rd = 7 -> stall stays 1 that cycle, drops to 0 the cycle after; loadBusyVector[7] = 0 while busyVector[7] = 1 until retireValid rd = 7.
- Three back-to-back writes to x3 (COUNT_WIDTH = 2) -> pendCount = 3; a fourth issue to x3 stalls. Retire x3 in the same cycle as the fourth issue -> no stall next cycle; count remains 3.
- Issue load x9; killValid rd = 9 with killLoadPending = 1 -> both vectors clear bit 9 after 1 cycle; scoreboardError = 0.
- retireValid rd = 4 with pendCount[4] = 0 -> scoreboardError = 1 and stays 1; counter remains 0.
- Issue to x0 / rs1 = x0 with a load in flight -> never busy, never stalls. Assert reset with x6 busy -> all vectors 0 next cycle.

Source files
------------

// File: rtl/register_scoreboard_if.sv
// Issue, writeback and flush events into the register scoreboard,
// plus the stall and busy status it reports back to decode.
interface register_scoreboard_if;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic        issueWritesRd;
    logic        issueIsLoad;
    logic [4:0]  issueRs1;
    logic [4:0]  issueRs2;
    logic        issueUsesRs1;
    logic        issueUsesRs2;
    logic        loadReadyValid;
    logic [4:0]  loadReadyRd;
    logic        retireValid;
    logic [4:0]  retireRd;
    logic        killValid;
    logic [4:0]  killRd;
    logic        killLoadPending;
    logic        stall;
    logic        issueAccept;
    logic [31:0] busyVector;
    logic [31:0] loadBusyVector;
    logic        scoreboardError;

    modport master (
        output issueValid, issueRd, issueWritesRd, issueIsLoad,
        output issueRs1, issueRs2, issueUsesRs1, issueUsesRs2,
        output loadReadyValid, loadReadyRd, retireValid, retireRd,
        output killValid, killRd, killLoadPending,
        input  stall, issueAccept, busyVector, loadBusyVector,
        input  scoreboardError
    );

    modport slave (
        input  issueValid, issueRd, issueWritesRd, issueIsLoad,
        input  issueRs1, issueRs2, issueUsesRs1, issueUsesRs2,
        input  loadReadyValid, loadReadyRd, retireValid, retireRd,
        input  killValid, killRd, killLoadPending,
        output stall, issueAccept, busyVector, loadBusyVector,
        output scoreboardError
    );
endinterface

// File: rtl/register_scoreboard.sv
// Per-GPR in-flight write and pending-load counters; drives the
// decode stall on load-use hazards and saturated counters.
module register_scoreboard #(
    parameter int COUNT_WIDTH      = 2,
    parameter int LOAD_COUNT_WIDTH = 2
) (
    input logic                clock,
    input logic                reset,
    register_scoreboard_if.slave sb
);
    localparam int CW = COUNT_WIDTH;
    localparam int LW = LOAD_COUNT_WIDTH;
    localparam logic [CW+1:0] PMAX = (CW+2)'((1 << CW) - 1);
    localparam logic [LW+1:0] LMAX = (LW+2)'((1 << LW) - 1);

    logic [CW-1:0] pend_q [32];
    logic [CW-1:0] pend_d [32];
    logic [LW-1:0] load_q [32];
    logic [LW-1:0] load_d [32];
    logic [31:0]   busy_q, busy_d;
    logic [31:0]   lbusy_q, lbusy_d;
    logic          err_q, err_d;

    logic hz_rs1, hz_rs2, full_rd, full_ld;
    logic stall, accept;

    always_comb begin
        hz_rs1  = sb.issueUsesRs1 && sb.issueRs1 != 5'd0
                  && load_q[sb.issueRs1] != '0;
        hz_rs2  = sb.issueUsesRs2 && sb.issueRs2 != 5'd0
                  && load_q[sb.issueRs2] != '0;
        full_rd = sb.issueWritesRd && sb.issueRd != 5'd0
                  && (CW+2)'(pend_q[sb.issueRd]) == PMAX;
        full_ld = sb.issueIsLoad && sb.issueRd != 5'd0
                  && (LW+2)'(load_q[sb.issueRd]) == LMAX;
        stall   = sb.issueValid
                  && (hz_rs1 || hz_rs2 || full_rd || full_ld);
        accept  = sb.issueValid && !stall;
    end

    logic [4:0]    ri;
    logic [CW+1:0] psum, pdec;
    logic [LW+1:0] lsum, ldec;

    // Each register nets its increments and decrements; anything that
    // falls outside [0, max] saturates and raises the sticky error.
    always_comb begin
        pend_d  = pend_q;
        load_d  = load_q;
        busy_d  = '0;
        lbusy_d = '0;
        err_d   = 1'b0;
        ri      = '0;
        psum    = '0;
        pdec    = '0;
        lsum    = '0;
        ldec    = '0;
        for (int r = 1; r < 32; r++) begin
            ri   = r[4:0];
            psum = (CW+2)'(pend_q[r])
                   + (CW+2)'(accept && sb.issueWritesRd && sb.issueRd == ri);
            pdec = (CW+2)'(sb.retireValid && sb.retireRd == ri)
                   + (CW+2)'(sb.killValid && sb.killRd == ri);
            lsum = (LW+2)'(load_q[r])
                   + (LW+2)'(accept && sb.issueIsLoad && sb.issueRd == ri);
            ldec = (LW+2)'(sb.loadReadyValid && sb.loadReadyRd == ri)
                   + (LW+2)'(sb.killValid && sb.killLoadPending
                             && sb.killRd == ri);
            if (psum < pdec) begin
                pend_d[r] = '0;
                err_d     = 1'b1;
            end else if (psum - pdec > PMAX) begin
                pend_d[r] = PMAX[CW-1:0];
                err_d     = 1'b1;
            end else begin
                pend_d[r] = CW'(psum - pdec);
            end
            if (lsum < ldec) begin
                load_d[r] = '0;
                err_d     = 1'b1;
            end else if (lsum - ldec > LMAX) begin
                load_d[r] = LMAX[LW-1:0];
                err_d     = 1'b1;
            end else begin
                load_d[r] = LW'(lsum - ldec);
            end
            busy_d[r]  = pend_d[r] != '0;
            lbusy_d[r] = load_d[r] != '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q  <= '{default: '0};
            load_q  <= '{default: '0};
            busy_q  <= '0;
            lbusy_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            lbusy_q <= lbusy_d;
            err_q   <= err_q | err_d;
        end
    end

    assign sb.stall           = stall;
    assign sb.issueAccept     = accept;
    assign sb.busyVector      = busy_q;
    assign sb.loadBusyVector  = lbusy_q;
    assign sb.scoreboardError = err_q;
endmodule
